// File: rtl/tinyrv_pkg.sv
// Shared definitions for the byte-phased register-file port: widths,
// sequencer state encoding and byte-lane helpers.
package tinyrv_pkg;

  localparam int REG_AW  = 4;
  localparam int NPHASE  = 4;
  localparam int PHASE_W = 2;
  localparam int XLEN    = 32;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NPHASE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  // Pick byte lane 'lane' out of a little-endian word (lane 0 = bits 7:0).
  function automatic logic [7:0] lane_sel(input logic [XLEN-1:0] word,
                                          input logic [PHASE_W-1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Replace byte lane 'lane' of a word, leaving the other lanes untouched.
  function automatic logic [XLEN-1:0] lane_insert(input logic [XLEN-1:0] word,
                                                  input logic [PHASE_W-1:0] lane,
                                                  input logic [7:0] b);
    logic [XLEN-1:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      2'd3:    w[31:24] = b;
      default: w = word;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/regfile_phase_sequencer_if.sv
// Core-side request/response bundle of the register-file phase sequencer.
// The core is the master; the sequencer is the slave.
interface regfile_phase_sequencer_if;
  import tinyrv_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [REG_AW-1:0] req_rs1;
  logic [REG_AW-1:0] req_rs2;
  logic [REG_AW-1:0] req_rd;
  logic              req_wen;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rs1_dat;
  logic [XLEN-1:0]   resp_rs2_dat;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_wen, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rs1_dat, resp_rs2_dat
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_wen, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rs1_dat, resp_rs2_dat
  );

endinterface

// File: rtl/regfile_phase_sequencer_byte_lane_assembler.sv
// Rebuilds a 32-bit operand from bytes returned one lane at a time.
module byte_lane_assembler
  import tinyrv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               we,
  input  logic [PHASE_W-1:0] lane,
  input  logic [7:0]         data_byte,
  output logic [XLEN-1:0]    word
);

  logic [XLEN-1:0] word_r;

  // Accumulate one byte per enabled cycle; each new transaction starts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= 32'h0000_0000;
    end else if (clear) begin
      word_r <= 32'h0000_0000;
    end else if (we) begin
      word_r <= lane_insert(word_r, lane, data_byte);
    end else begin
      word_r <= word_r;
    end
  end

  assign word = word_r;

endmodule

// File: rtl/regfile_phase_sequencer.sv
// Initiator side of the byte-phased register-file port. Serialises one
// read/read/optional-write transaction into four byte phases and reassembles
// the returned read bytes into two 32-bit operands.
module regfile_phase_sequencer
  import tinyrv_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_phase_sequencer_if.slave bus,
  output logic [PHASE_W-1:0] mux_phase,
  output logic [REG_AW-1:0]  rs1,
  output logic [REG_AW-1:0]  rs2,
  output logic [REG_AW-1:0]  rd,
  output logic [7:0]         rd_dat,
  input  logic [7:0]         rs1_dat,
  input  logic [7:0]         rs2_dat
);

  seq_state_e         state_r;
  logic [PHASE_W-1:0] phase_r;
  logic [REG_AW-1:0]  rs1_r;
  logic [REG_AW-1:0]  rs2_r;
  logic [REG_AW-1:0]  rd_r;
  logic [7:0]         rd_dat_r;
  logic [XLEN-1:0]    wdata_r;
  logic               req_ready_r;
  logic               resp_valid_r;

  logic               new_req_s;
  logic [REG_AW-1:0]  eff_rd_s;
  logic               cap_we_s;
  logic [PHASE_W-1:0] cap_lane_s;
  logic [XLEN-1:0]    word1_s;
  logic [XLEN-1:0]    word2_s;

  // Request handshake and effective write address (no write without req_wen)
  always_comb begin
    new_req_s = 1'b0;
    eff_rd_s  = 4'd0;
    if ((state_r == IDLE) && bus.req_valid && req_ready_r) begin
      new_req_s = 1'b1;
    end else begin
      new_req_s = 1'b0;
    end
    if (bus.req_wen) begin
      eff_rd_s = bus.req_rd;
    end else begin
      eff_rd_s = 4'd0;
    end
  end

  // Sequencer FSM with registered port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      phase_r      <= 2'd0;
      rs1_r        <= 4'd0;
      rs2_r        <= 4'd0;
      rd_r         <= 4'd0;
      rd_dat_r     <= 8'h00;
      wdata_r      <= 32'h0000_0000;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (new_req_s) begin
            state_r     <= XFER;
            phase_r     <= 2'd0;
            rs1_r       <= bus.req_rs1;
            rs2_r       <= bus.req_rs2;
            rd_r        <= eff_rd_s;
            wdata_r     <= bus.req_wdata;
            rd_dat_r    <= lane_sel(bus.req_wdata, 2'd0);
            req_ready_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        XFER: begin
          if (phase_r == LAST_PHASE) begin
            // Write port goes quiet after the last phase so no byte repeats
            rd_r     <= 4'd0;
            rd_dat_r <= 8'h00;
            if (RD_LAT == 1) begin
              state_r <= DRAIN;
            end else begin
              state_r      <= RESP;
              phase_r      <= 2'd0;
              resp_valid_r <= 1'b1;
            end
          end else begin
            phase_r  <= phase_r + 2'd1;
            rd_dat_r <= lane_sel(wdata_r, phase_r + 2'd1);
          end
        end
        DRAIN: begin
          state_r      <= RESP;
          phase_r      <= 2'd0;
          resp_valid_r <= 1'b1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r      <= IDLE;
          phase_r      <= 2'd0;
          rd_r         <= 4'd0;
          rd_dat_r     <= 8'h00;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (RD_LAT == 0) begin : g_lat0
      // Read bytes belong to the phase being driven right now
      always_comb begin
        cap_we_s   = (state_r == XFER);
        cap_lane_s = phase_r;
      end
    end else begin : g_lat1
      logic               dly_vld_r;
      logic [PHASE_W-1:0] dly_lane_r;

      // Remember the phase driven last cycle; its read bytes arrive this cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_vld_r  <= 1'b0;
          dly_lane_r <= 2'd0;
        end else begin
          dly_vld_r  <= (state_r == XFER);
          dly_lane_r <= phase_r;
        end
      end

      // Capture strobe follows the delayed phase
      always_comb begin
        cap_we_s   = dly_vld_r;
        cap_lane_s = dly_lane_r;
      end
    end
  endgenerate

  byte_lane_assembler u_asm_rs1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (new_req_s),
    .we        (cap_we_s),
    .lane      (cap_lane_s),
    .data_byte (rs1_dat),
    .word      (word1_s)
  );

  byte_lane_assembler u_asm_rs2 (
    .clk       (clk),
    .rst       (rst),
    .clear     (new_req_s),
    .we        (cap_we_s),
    .lane      (cap_lane_s),
    .data_byte (rs2_dat),
    .word      (word2_s)
  );

  assign mux_phase        = phase_r;
  assign rs1              = rs1_r;
  assign rs2              = rs2_r;
  assign rd               = rd_r;
  assign rd_dat           = rd_dat_r;
  assign bus.req_ready    = req_ready_r;
  assign bus.resp_valid   = resp_valid_r;
  assign bus.resp_rs1_dat = word1_s;
  assign bus.resp_rs2_dat = word2_s;

endmodule
